single_port_ram_param: RTL and testbench
========================================

SINGLE_PORT_RAM_PARAM -- requirements
Module: single_port_ram_param

Interface
REQ-001 Parameter DATA_WIDTH, default 16: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 6: address width; depth DEPTH = 2**ADDR_WIDTH words.
REQ-003 Parameter READ_MODE, default 0: read-during-write mode; 0 = write-first, 1 = read-first, 2 = no-change.
REQ-004 Parameter OUT_REG, default 0: 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency.
REQ-005 Parameter CLEAR_VAL, default 0 (DATA_WIDTH bits): value written to every word by a clear sweep.
REQ-006 The design has one clock and a synchronous, active-high reset: clk and rst.
REQ-007 Port list (name, direction, width, meaning):
- clk, in, 1: clock; all logic on the rising edge.
- rst, in, 1: synchronous active-high reset.
- en, in, 1: access request this cycle.
- we, in, 1: 1 = write, 0 = read; only meaningful with en.
- be, in, DATA_WIDTH/8: byte-lane write enables; bit i covers data[8i+7:8i].
- addr, in, ADDR_WIDTH: word address.
- data, in, DATA_WIDTH: write data.
- clr, in, 1: request a full-memory clear sweep.
- busy, out, 1: clear sweep in progress; accesses ignored.
- q, out, DATA_WIDTH: read data.
- q_valid, out, 1: q carries the result of an accepted access.

Function
REQ-008 An access is accepted when en=1 and busy=0 at a rising edge; otherwise the memory and q are unchanged and no q_valid is produced.
REQ-009 Accepted write: each lane i with be[i]=1 SHALL take data lane i at addr; lanes with be[i]=0 keep their contents; be=0 writes nothing.
REQ-010 Accepted read (we=0): q = mem[addr] with q_valid=1. With OUT_REG=0 this appears 1 cycle after acceptance; with OUT_REG=1 it appears 2 cycles after.
REQ-011 Accepted write, READ_MODE=0: q SHALL present the merged new word at the read latency, with q_valid=1.
REQ-012 Accepted write, READ_MODE=1: q SHALL present the pre-write word at the read latency, with q_valid=1.
REQ-013 Accepted write, READ_MODE=2: q SHALL hold its previous value and q_valid SHALL be 0 for that access.
REQ-014 q_valid is a single-cycle pulse per accepted access; back-to-back accesses give back-to-back pulses (full throughput, one access per cycle).
REQ-015 Between valid results, q SHALL hold its last value.
REQ-016 FSM states:
- IDLE: accepts accesses; busy=0.
- CLEAR: a counter clr_addr sweeps 0..DEPTH-1, one word per cycle, writing CLEAR_VAL to all lanes; busy=1.
REQ-017 Transitions:
- IDLE -> CLEAR when clr=1.
- CLEAR -> IDLE on the cycle after the write to DEPTH-1.
- A sweep therefore keeps busy high for exactly DEPTH cycles.
REQ-018 clr=1 while in CLEAR SHALL be ignored; the sweep does not restart.
REQ-019 If clr=1 and en=1 arrive in the same IDLE cycle, clr wins: the access is not accepted and the sweep starts.
REQ-020 Any access already inside the OUT_REG pipeline when a sweep starts SHALL still deliver its q/q_valid.
REQ-021 clr_addr SHALL wrap to 0 only on entry to CLEAR, never silently during a sweep.

Reset
REQ-022 rst=1 at a rising edge SHALL set q=0, q_valid=0, flush the output pipeline, set clr_addr=0, and enter CLEAR with busy=1 on the next cycle.
REQ-023 While rst is held, the FSM remains at CLEAR with clr_addr=0; the sweep begins on the first edge with rst=0 and busy falls DEPTH cycles later.
REQ-024 rst asserted mid-sweep or mid-access SHALL restart the sweep from address 0; no partial write or pending read completes.
REQ-025 Memory contents are defined only after the post-reset sweep completes.

Verification (DATA_WIDTH=16, ADDR_WIDTH=6, CLEAR_VAL=16'h0000 unless stated)
REQ-026 Reset, wait for busy=0, read addr 5 and addr 63 -> q=16'h0000 both; busy high exactly 64 cycles after rst release.
REQ-027 OUT_REG=0: write 16'hA1B2 to addr 1 with be=2'b11, then read addr 1 -> q=16'hA1B2, q_valid 1 cycle after the read edge; with OUT_REG=1, 2 cycles after.
REQ-028 Over addr 1=16'hA1B2, write data=16'h3344 with be=2'b01, then read -> q=16'hA144.
REQ-029 Read-during-write at addr 2 (holding 16'h0001) with data=16'h0002: READ_MODE 0 -> q=16'h0002; mode 1 -> q=16'h0001; mode 2 -> q unchanged, no q_valid.
REQ-030 Write 16'hFFFF to addr 7, pulse clr, issue a read during busy -> no q_valid while busy; after busy falls, read addr 7 -> 16'h0000.
REQ-031 Assert rst at sweep cycle 30 for one cycle -> busy stays high 64 cycles from rst release; q=0 and q_valid=0 on the cycle after rst.

Source files
------------

// File: rtl/single_port_ram_param.sv
// Parameterised single-port RAM with byte-lane writes, selectable read-during-write
// behaviour, optional output register and a hardware clear sweep.
module single_port_ram_param #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    READ_MODE  = 0,
    parameter int                    OUT_REG    = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VAL  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic                    clr,
    output logic                    busy,
    output logic [DATA_WIDTH-1:0]   q,
    output logic                    q_valid
);

    localparam int                    NB        = DATA_WIDTH / 8;
    localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    accept_s;
    logic [DATA_WIDTH-1:0]   old_word_s;
    logic [DATA_WIDTH-1:0]   merged_s;
    logic                    res_valid_s;
    logic [DATA_WIDTH-1:0]   res_data_s;
    logic                    mem_we_s;
    logic [ADDR_WIDTH-1:0]   mem_addr_s;
    logic [DATA_WIDTH-1:0]   mem_wdata_s;

    logic                    s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0]   s1_data_q, s1_data_d;
    logic                    s2_valid_q, s2_valid_d;
    logic [DATA_WIDTH-1:0]   s2_data_q, s2_data_d;

    // Clear-sweep FSM: clr_addr restarts only on entry and parks on the last word at exit.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_ONE;
                end
            end
            default: begin
                state_d    = ST_CLEAR;
                clr_addr_d = '0;
            end
        endcase
    end

    // Access decode: clr beats en in the same cycle, and a reset edge cancels everything.
    always_comb begin
        accept_s   = en && (state_q == ST_IDLE) && !clr && !rst;
        old_word_s = mem[addr];
        merged_s   = old_word_s;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                merged_s[8*i +: 8] = data[8*i +: 8];
            end else begin
                merged_s[8*i +: 8] = old_word_s[8*i +: 8];
            end
        end

        res_valid_s = 1'b0;
        res_data_s  = old_word_s;
        if (accept_s && !we) begin
            res_valid_s = 1'b1;
        end else if (accept_s && we) begin
            case (READ_MODE)
                0: begin
                    res_valid_s = 1'b1;
                    res_data_s  = merged_s;
                end
                1: res_valid_s = 1'b1;
                default: res_valid_s = 1'b0;
            endcase
        end else begin
            res_valid_s = 1'b0;
        end

        mem_we_s    = 1'b0;
        mem_addr_s  = addr;
        mem_wdata_s = merged_s;
        if (rst) begin
            mem_we_s = 1'b0;
        end else if (state_q == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = clr_addr_q;
            mem_wdata_s = CLEAR_VAL;
        end else if (accept_s && we) begin
            mem_we_s = 1'b1;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Result pipeline: each stage holds its data between valid results.
    always_comb begin
        s1_valid_d = res_valid_s;
        s1_data_d  = res_valid_s ? res_data_s : s1_data_q;
        s2_valid_d = s1_valid_q;
        s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
    end

    // Storage array; whole merged word is rewritten, unselected lanes carry old data.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_addr_s] <= mem_wdata_s;
        end
    end

    // Control and output registers with synchronous reset into a fresh sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
        end
    end

    assign busy    = (state_q == ST_CLEAR);
    assign q       = (OUT_REG != 0) ? s2_data_q  : s1_data_q;
    assign q_valid = (OUT_REG != 0) ? s2_valid_q : s1_valid_q;

endmodule

// File: tb/tb_single_port_ram_param.sv
// Self-checking bench: four RAM configurations share one stimulus stream; a per-instance
// scoreboard queue holds the expected result and the cycle it must appear on.
module tb_single_port_ram_param;

    logic        clk = 1'b0;
    logic        rst, en, we, clr;
    logic [1:0]  be;
    logic [5:0]  addr;
    logic [15:0] data;

    logic [15:0] q_a    [4];
    logic        qv_a   [4];
    logic        busy_a [4];

    typedef struct {
        int          due;
        logic [15:0] d;
    } sb_t;

    sb_t         sbq [4][$];
    logic [15:0] last_exp [4];
    logic [15:0] mdl [64];
    int          rm_cfg  [4] = '{0, 1, 2, 1};
    int          lat_cfg [4] = '{0, 0, 0, 1};
    bit          mdl_busy;
    bit          mon_on;
    logic        rst_edge;
    int          cyc;
    int          n_cmp;
    int          n_err;

    always #5 clk = ~clk;

    single_port_ram_param #(.READ_MODE(0), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .data(data),
        .clr(clr), .busy(busy_a[0]), .q(q_a[0]), .q_valid(qv_a[0]));
    single_port_ram_param #(.READ_MODE(1), .OUT_REG(0)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .data(data),
        .clr(clr), .busy(busy_a[1]), .q(q_a[1]), .q_valid(qv_a[1]));
    single_port_ram_param #(.READ_MODE(2), .OUT_REG(0)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .data(data),
        .clr(clr), .busy(busy_a[2]), .q(q_a[2]), .q_valid(qv_a[2]));
    single_port_ram_param #(.READ_MODE(1), .OUT_REG(1)) u_dut3 (
        .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .data(data),
        .clr(clr), .busy(busy_a[3]), .q(q_a[3]), .q_valid(qv_a[3]));

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= rst;
    end

    // Scoreboard monitor: result due this cycle, zeros after a reset edge, otherwise hold.
    always @(negedge clk) begin
        logic        exp_v;
        logic [15:0] exp_d;
        if (mon_on) begin
            for (int k = 0; k < 4; k++) begin
                if (rst_edge) begin
                    sbq[k].delete();
                    last_exp[k] = 16'h0000;
                    exp_v = 1'b0;
                    exp_d = 16'h0000;
                end else if (sbq[k].size() > 0 && sbq[k][0].due == cyc) begin
                    exp_v = 1'b1;
                    exp_d = sbq[k][0].d;
                    last_exp[k] = exp_d;
                    void'(sbq[k].pop_front());
                end else begin
                    exp_v = 1'b0;
                    exp_d = last_exp[k];
                end
                n_cmp++;
                if (qv_a[k] !== exp_v || q_a[k] !== exp_d) begin
                    n_err++;
                    $display("FAIL out%0d cyc=%0d: got q=%h q_valid=%b, want q=%h q_valid=%b",
                             k, cyc, q_a[k], qv_a[k], exp_d, exp_v);
                end
            end
        end
    end

    // One stimulus cycle; expectations are pushed only for accesses the RAM should accept.
    task automatic drive(input logic e, input logic w, input logic [1:0] b,
                         input logic [5:0] a, input logic [15:0] d, input logic c);
        logic [15:0] old_w, mrg;
        sb_t         ent;
        en = e; we = w; be = b; addr = a; data = d; clr = c;
        if (!mdl_busy && !rst) begin
            if (c) begin
                for (int i = 0; i < 64; i++) mdl[i] = 16'h0000;
                mdl_busy = 1'b1;
            end else if (e) begin
                old_w = mdl[a];
                mrg   = old_w;
                for (int l = 0; l < 2; l++) if (b[l]) mrg[8*l +: 8] = d[8*l +: 8];
                for (int k = 0; k < 4; k++) begin
                    ent.due = cyc + 1 + lat_cfg[k];
                    if (!w) begin
                        ent.d = old_w;
                        sbq[k].push_back(ent);
                    end else if (rm_cfg[k] == 0) begin
                        ent.d = mrg;
                        sbq[k].push_back(ent);
                    end else if (rm_cfg[k] == 1) begin
                        ent.d = old_w;
                        sbq[k].push_back(ent);
                    end
                end
                if (w) mdl[a] = mrg;
            end
        end
        @(posedge clk); #1;
        en = 1'b0; we = 1'b0; clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 64; i++) mdl[i] = 16'h0000;
        mdl_busy = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Counts cycles with busy high from the first cycle of a sweep; optionally pokes clr/en mid-sweep.
    task automatic count_busy(input string nm, input int inj_clr, input int inj_rd);
        int n [4];
        for (int k = 0; k < 4; k++) n[k] = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) if (busy_a[k]) n[k]++;
            if (!busy_a[0] && !busy_a[1] && !busy_a[2] && !busy_a[3]) break;
            @(posedge clk); #1;
            clr = (t == inj_clr);
            en  = (t == inj_rd);
            we  = 1'b0;
            addr = 6'd7;
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (n[k] !== 64) begin
                n_err++;
                $display("FAIL %s busy_len%0d: got %0d cycles, want 64", nm, k, n[k]);
            end
        end
        clr = 1'b0; en = 1'b0;
        mdl_busy = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; we = 1'b0; clr = 1'b0;
        be = 2'b00; addr = 6'd0; data = 16'h0000;
        for (int i = 0; i < 64; i++) mdl[i] = 16'h0000;
        mdl_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mon_on = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (busy_a[k] !== 1'b1) begin
                n_err++;
                $display("FAIL reset_busy%0d: got %b, want 1", k, busy_a[k]);
            end
        end
        rst = 1'b0;
        count_busy("reset", -1, -1);
        drive(1'b1, 1'b0, 2'b00, 6'd5, 16'h0000, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 6'd63, 16'h0000, 1'b0);
    endtask

    task automatic test_write_read();
        drive(1'b1, 1'b1, 2'b11, 6'd1, 16'hA1B2, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 6'd1, 16'h0000, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 2'b00, 6'd0, 16'h0000, 1'b0);
    endtask

    task automatic test_byte_enable();
        drive(1'b1, 1'b1, 2'b01, 6'd1, 16'h3344, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 6'd1, 16'h0000, 1'b0);
        drive(1'b1, 1'b1, 2'b10, 6'd1, 16'h5566, 1'b0);
        drive(1'b1, 1'b1, 2'b00, 6'd1, 16'hFFFF, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 6'd1, 16'h0000, 1'b0);
    endtask

    task automatic test_rdw();
        drive(1'b1, 1'b1, 2'b11, 6'd2, 16'h0001, 1'b0);
        drive(1'b0, 1'b0, 2'b00, 6'd0, 16'h0000, 1'b0);
        drive(1'b1, 1'b1, 2'b11, 6'd2, 16'h0002, 1'b0);
        drive(1'b0, 1'b0, 2'b00, 6'd0, 16'h0000, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 6'd2, 16'h0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  6'($urandom_range(16, 23)), 16'($urandom), 1'b0);
        end
        repeat (3) drive(1'b0, 1'b0, 2'b00, 6'd0, 16'h0000, 1'b0);
    endtask

    task automatic test_clear();
        drive(1'b1, 1'b1, 2'b11, 6'd7, 16'hFFFF, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 6'd7, 16'h0000, 1'b1);
        count_busy("clear", 10, 5);
        drive(1'b1, 1'b0, 2'b00, 6'd7, 16'h0000, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 6'd1, 16'h0000, 1'b0);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 2'b11, 6'd9, 16'h5555, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 6'd9, 16'h0000, 1'b0);
        do_reset();
        repeat (30) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if (busy_a[0] !== 1'b1) begin
            n_err++;
            $display("FAIL mid_sweep_busy: got %b, want 1", busy_a[0]);
        end
        do_reset();
        count_busy("reset_mid", -1, -1);
        drive(1'b1, 1'b0, 2'b00, 6'd9, 16'h0000, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 6'd2, 16'h0000, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        cyc = 0; n_cmp = 0; n_err = 0; mon_on = 1'b0; rst_edge = 1'b1;
        for (int k = 0; k < 4; k++) last_exp[k] = 16'h0000;
        test_reset();
        test_write_read();
        test_byte_enable();
        test_rdw();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        repeat (4) drive(1'b0, 1'b0, 2'b00, 6'd0, 16'h0000, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (sbq[k].size() != 0) begin
                n_err++;
                $display("FAIL drain%0d: got %0d results outstanding, want 0", k, sbq[k].size());
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
